// File: rtl/game_pkg.sv
// Shared game constants: FSM encodings for the player-hit controller and
// sprite sizes used by the draw blocks, missile controllers and collision logic.
package game_pkg;

  typedef enum logic [1:0] {
    ALIVE  = 2'b00,
    INVULN = 2'b01,
    DEAD   = 2'b10
  } hit_state_e;

  localparam int PLAYER_W  = 48;
  localparam int PLAYER_H  = 64;
  localparam int MISSILE_W = 4;
  localparam int MISSILE_H = 16;

  // Screen coordinate plus a size, widened to 13 bits so edges near 4095 never wrap.
  function automatic logic [12:0] edge_add(input logic [11:0] pos, input int unsigned size);
    return {1'b0, pos} + 13'(size);
  endfunction

endpackage

// File: rtl/rect_overlap.sv
// Registered half-open rectangle intersect test between rectangle A and an
// enable-qualified rectangle B, with 13-bit edge sums.
module rect_overlap
  import game_pkg::*;
#(
  parameter int A_W = 48,
  parameter int A_H = 64,
  parameter int B_W = 4,
  parameter int B_H = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [11:0] a_x_i,
  input  logic [11:0] a_y_i,
  input  logic [11:0] b_x_i,
  input  logic [11:0] b_y_i,
  input  logic        b_en_i,
  output logic        ov_o
);

  logic ov_q;
  logic ov_d;

  // Strict compares make touching edges a miss.
  always_comb begin
    ov_d = b_en_i
        && ({1'b0, b_x_i} < edge_add(a_x_i, A_W))
        && ({1'b0, a_x_i} < edge_add(b_x_i, B_W))
        && ({1'b0, b_y_i} < edge_add(a_y_i, A_H))
        && ({1'b0, a_y_i} < edge_add(b_y_i, B_H));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) ov_q <= 1'b0;
    else       ov_q <= ov_d;
  end

  assign ov_o = ov_q;

endmodule

// File: rtl/ctl_player_hit.sv
// Player hit controller: counts enemy-missile hits, runs the invulnerability
// window with blink, retires the missile via a clear handshake, flags game over.
module ctl_player_hit #(
  parameter int PLAYER_W      = game_pkg::PLAYER_W,
  parameter int PLAYER_H      = game_pkg::PLAYER_H,
  parameter int MISSILE_W     = game_pkg::MISSILE_W,
  parameter int MISSILE_H     = game_pkg::MISSILE_H,
  parameter int LIVES_INIT    = 3,
  parameter int INVULN_CYCLES = 6500000,
  parameter int BLINK_CYCLES  = 650000
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic [11:0] missile_x,
  input  logic [11:0] missile_y,
  input  logic        missile_on,
  input  logic [11:0] player_x,
  input  logic [11:0] player_y,
  input  logic        game_restart,
  output logic        hit_pulse,
  output logic        missile_clear,
  output logic [2:0]  lives_out,
  output logic        invuln_out,
  output logic        blink_out,
  output logic        game_over
);

  import game_pkg::*;

  localparam int CW = $clog2(INVULN_CYCLES + 1);
  localparam int BW = $clog2(BLINK_CYCLES + 1);
  localparam logic [CW-1:0] INV_LAST   = CW'(INVULN_CYCLES - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);
  localparam logic [2:0]    LIVES_RST  = 3'(LIVES_INIT);

  hit_state_e    state_q;
  logic          ov_q;
  logic          hit_d;
  logic [CW-1:0] inv_cnt_q;
  logic [BW-1:0] blink_cnt_q;
  logic          hit_pulse_q;
  logic          clear_q;
  logic [2:0]    lives_q;
  logic          invuln_q;
  logic          blink_q;
  logic          game_over_q;

  rect_overlap #(
    .A_W (PLAYER_W),
    .A_H (PLAYER_H),
    .B_W (MISSILE_W),
    .B_H (MISSILE_H)
  ) u_overlap (
    .clk_i  (pclk),
    .rst_i  (rst),
    .a_x_i  (player_x),
    .a_y_i  (player_y),
    .b_x_i  (missile_x),
    .b_y_i  (missile_y),
    .b_en_i (missile_on),
    .ov_o   (ov_q)
  );

  // A restart on the same edge suppresses the hit entirely.
  assign hit_d = ov_q && (state_q == ALIVE) && !game_restart;

  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q     <= ALIVE;
      inv_cnt_q   <= '0;
      blink_cnt_q <= '0;
      hit_pulse_q <= 1'b0;
      clear_q     <= 1'b0;
      lives_q     <= LIVES_RST;
      invuln_q    <= 1'b0;
      blink_q     <= 1'b1;
      game_over_q <= 1'b0;
    end else begin
      hit_pulse_q <= hit_d;

      if (hit_d)            clear_q <= 1'b1;
      else if (!missile_on) clear_q <= 1'b0;

      if (game_restart) begin
        state_q     <= ALIVE;
        inv_cnt_q   <= '0;
        blink_cnt_q <= '0;
        lives_q     <= LIVES_RST;
        invuln_q    <= 1'b0;
        blink_q     <= 1'b1;
        game_over_q <= 1'b0;
      end else begin
        case (state_q)
          ALIVE: begin
            if (hit_d) begin
              lives_q     <= lives_q - 3'd1;
              inv_cnt_q   <= '0;
              blink_cnt_q <= '0;
              if (lives_q == 3'd1) begin
                state_q     <= DEAD;
                game_over_q <= 1'b1;
                blink_q     <= 1'b0;
              end else begin
                state_q  <= INVULN;
                invuln_q <= 1'b1;
              end
            end
          end
          INVULN: begin
            if (inv_cnt_q == INV_LAST) begin
              state_q     <= ALIVE;
              inv_cnt_q   <= '0;
              blink_cnt_q <= '0;
              invuln_q    <= 1'b0;
              blink_q     <= 1'b1;
            end else begin
              inv_cnt_q <= inv_cnt_q + 1'b1;
              if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_q <= '0;
                blink_q     <= ~blink_q;
              end else begin
                blink_cnt_q <= blink_cnt_q + 1'b1;
              end
            end
          end
          DEAD: begin
            game_over_q <= 1'b1;
            blink_q     <= 1'b0;
          end
          default: state_q <= ALIVE;
        endcase
      end
    end
  end

  assign hit_pulse     = hit_pulse_q;
  assign missile_clear = clear_q;
  assign lives_out     = lives_q;
  assign invuln_out    = invuln_q;
  assign blink_out     = blink_q;
  assign game_over     = game_over_q;

endmodule

// File: tb/tb_ctl_player_hit.sv
// Directed bench for ctl_player_hit: geometry vector table plus hand-written
// sequences for handshake, invulnerability/blink, reset, game over and restart.
module tb_ctl_player_hit;

  logic        pclk = 1'b0;
  logic        rst;
  logic [11:0] missile_x, missile_y, player_x, player_y;
  logic        missile_on;
  logic        game_restart;

  logic       hit_pulse, missile_clear, invuln_out, blink_out, game_over;
  logic [2:0] lives_out;
  logic       hit_pulse1, missile_clear1, invuln_out1, blink_out1, game_over1;
  logic [2:0] lives_out1;

  int n_vec = 0;
  int n_bad = 0;

  always #5 pclk = ~pclk;

  ctl_player_hit #(.LIVES_INIT(3), .INVULN_CYCLES(20), .BLINK_CYCLES(4)) dut (
    .pclk(pclk), .rst(rst), .missile_x(missile_x), .missile_y(missile_y),
    .missile_on(missile_on), .player_x(player_x), .player_y(player_y),
    .game_restart(game_restart), .hit_pulse(hit_pulse), .missile_clear(missile_clear),
    .lives_out(lives_out), .invuln_out(invuln_out), .blink_out(blink_out),
    .game_over(game_over)
  );

  ctl_player_hit #(.LIVES_INIT(1), .INVULN_CYCLES(20), .BLINK_CYCLES(4)) dut1 (
    .pclk(pclk), .rst(rst), .missile_x(missile_x), .missile_y(missile_y),
    .missile_on(missile_on), .player_x(player_x), .player_y(player_y),
    .game_restart(game_restart), .hit_pulse(hit_pulse1), .missile_clear(missile_clear1),
    .lives_out(lives_out1), .invuln_out(invuln_out1), .blink_out(blink_out1),
    .game_over(game_over1)
  );

  typedef struct {
    logic [11:0] mx, my, px, py;
    logic        on;
    logic        hit;
  } vec_t;

  vec_t vt[12];

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    game_restart = 1'b0;
    missile_on = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic set_overlap();
    player_x = 12'd500; player_y = 12'd700;
    missile_x = 12'd520; missile_y = 12'd690;
    missile_on = 1'b1;
  endtask

  initial begin
    int hits, k0, j;
    logic eh, eb, ei;

    vt[0]  = '{mx:520,  my:690,  px:500,  py:700,  on:1, hit:1};
    vt[1]  = '{mx:496,  my:710,  px:500,  py:700,  on:1, hit:0};
    vt[2]  = '{mx:497,  my:710,  px:500,  py:700,  on:1, hit:1};
    vt[3]  = '{mx:548,  my:710,  px:500,  py:700,  on:1, hit:0};
    vt[4]  = '{mx:547,  my:710,  px:500,  py:700,  on:1, hit:1};
    vt[5]  = '{mx:520,  my:684,  px:500,  py:700,  on:1, hit:0};
    vt[6]  = '{mx:520,  my:685,  px:500,  py:700,  on:1, hit:1};
    vt[7]  = '{mx:520,  my:764,  px:500,  py:700,  on:1, hit:0};
    vt[8]  = '{mx:520,  my:763,  px:500,  py:700,  on:1, hit:1};
    vt[9]  = '{mx:520,  my:690,  px:500,  py:700,  on:0, hit:0};
    vt[10] = '{mx:4094, my:4094, px:4090, py:4090, on:1, hit:1};
    vt[11] = '{mx:4095, my:0,    px:0,    py:0,    on:1, hit:0};

    missile_x = '0; missile_y = '0; player_x = '0; player_y = '0;
    do_reset();
    chk("rst_hit", hit_pulse, 0);
    chk("rst_clear", missile_clear, 0);
    chk("rst_lives", lives_out, 3);
    chk("rst_invuln", invuln_out, 0);
    chk("rst_blink", blink_out, 1);
    chk("rst_gameover", game_over, 0);
    chk("rst_lives1", lives_out1, 1);

    // Geometry table: inputs held for one edge, result two edges after drive.
    for (int v = 0; v < 12; v++) begin
      do_reset();
      missile_x = vt[v].mx; missile_y = vt[v].my;
      player_x = vt[v].px;  player_y = vt[v].py;
      missile_on = vt[v].on;
      tick();
      missile_on = 1'b0;
      tick();
      chk($sformatf("vec%0d_hit", v), hit_pulse, vt[v].hit);
      chk($sformatf("vec%0d_lives", v), lives_out, vt[v].hit ? 2 : 3);
      chk($sformatf("vec%0d_invuln", v), invuln_out, vt[v].hit);
      chk($sformatf("vec%0d_clear", v), missile_clear, vt[v].hit);
      tick();
      chk($sformatf("vec%0d_hit_next", v), hit_pulse, 0);
    end

    // Missile off with overlapping coordinates.
    do_reset();
    set_overlap();
    missile_on = 1'b0;
    hits = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (hit_pulse) hits++;
    end
    chk("off_hits", hits, 0);
    chk("off_lives", lives_out, 3);

    // Clear handshake.
    do_reset();
    set_overlap();
    tick();
    tick();
    chk("hs_hit", hit_pulse, 1);
    chk("hs_clear_rise", missile_clear, 1);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("hs_clear_hold%0d", i), missile_clear, 1);
    end
    missile_on = 1'b0;
    tick();
    chk("hs_clear_fall", missile_clear, 0);

    // Reset mid-invulnerability and mid-handshake.
    do_reset();
    set_overlap();
    tick();
    tick();
    tick();
    chk("midrst_pre_invuln", invuln_out, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_clear", missile_clear, 0);
    chk("midrst_invuln", invuln_out, 0);
    chk("midrst_lives", lives_out, 3);
    chk("midrst_blink", blink_out, 1);

    // Continuous overlap: hits after edges 1, 22, 43; third one kills.
    do_reset();
    set_overlap();
    for (int i = 0; i <= 43; i++) begin
      tick();
      hits = (i >= 1) + (i >= 22) + (i >= 43);
      k0 = (i >= 43) ? 43 : (i >= 22) ? 22 : (i >= 1) ? 1 : -1;
      eh = (i == 1) || (i == 22) || (i == 43);
      if (i >= 43) begin
        eb = 1'b0; ei = 1'b0;
      end else if (k0 < 0) begin
        eb = 1'b1; ei = 1'b0;
      end else begin
        j = i - k0;
        ei = (j < 20);
        eb = (j < 20) ? (((j / 4) % 2) == 0) : 1'b1;
      end
      chk($sformatf("inv_hit@%0d", i), hit_pulse, eh);
      chk($sformatf("inv_blink@%0d", i), blink_out, eb);
      chk($sformatf("inv_invuln@%0d", i), invuln_out, ei);
      chk($sformatf("inv_lives@%0d", i), lives_out, 3 - hits);
    end
    chk("inv_gameover", game_over, 1);

    // Game over and restart on the single-life instance.
    do_reset();
    set_overlap();
    tick();
    tick();
    chk("go_hit", hit_pulse1, 1);
    chk("go_lives", lives_out1, 0);
    chk("go_flag", game_over1, 1);
    chk("go_blink", blink_out1, 0);
    hits = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (hit_pulse1) hits++;
    end
    chk("go_no_more_hits", hits, 0);
    chk("go_lives_hold", lives_out1, 0);
    game_restart = 1'b1;
    tick();
    chk("rs_lives", lives_out1, 1);
    chk("rs_gameover", game_over1, 0);
    chk("rs_blink", blink_out1, 1);
    chk("rs_hit", hit_pulse1, 0);
    chk("rs_clear_kept", missile_clear1, 1);
    tick();
    chk("rs_prio_hit", hit_pulse1, 0);
    chk("rs_prio_lives", lives_out1, 1);
    game_restart = 1'b0;
    tick();
    chk("rs_after_hit", hit_pulse1, 1);
    chk("rs_after_lives", lives_out1, 0);
    chk("rs_after_gameover", game_over1, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
